// File: rtl/bank_grant_scheduler.sv
// bank_grant_scheduler
//   Round-robin grant scheduler for 2**N requesters. A grant is held until the
//   holder signals done or drops its request. The rotating pointer then moves
//   past the old holder and the scheduler re-arbitrates on the same edge, so
//   back-to-back grants have no idle bubble.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : a hold counter forces a release after TIMEOUT grant cycles
//                 and pulses timeout_flag for one cycle.
//     undefined : no counter, timeout_flag is tied low, grants are held
//                 indefinitely until released.
//
// Parameters
//   N        requester-index width (2**N requesters)
//   TIMEOUT  maximum hold cycles when ARB_TIMEOUT_EN is defined (2..255)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           per-requester level request
//   done          current holder releases this cycle (ignored when idle)
//   code          registered index of the current holder
//   enabler       registered, high while a grant is active
//   grant         one-hot grant, grant[i] = enabler & (code == i)
//   timeout_flag  one-cycle pulse on a forced release
module bank_grant_scheduler #(
  parameter int N       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**N-1:0]   req,
  input  logic              done,
  output logic [N-1:0]      code,
  output logic              enabler,
  output logic [2**N-1:0]   grant,
  output logic              timeout_flag
);

  localparam int R = 2**N;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg;
  logic [N-1:0]   ptr_reg;

  // One arbiter serves both cases: from IDLE it searches from ptr, on a
  // release it searches from code+1, which is the pointer being written on
  // that same edge. In GRANT without a release its result is unused.
  logic [N-1:0]   base;
  logic [N-1:0]   rot_idx [R];
  logic [R-1:0]   rot;
  logic           hit;
  logic [N-1:0]   off;
  logic [N-1:0]   pick;

  logic           drop;
  logic           release_now;
  logic           timeout_hit;

  assign base = (state_reg == GRANT) ? code + 1'b1 : ptr_reg;

  // rot[k] is the request seen k positions after base; N-bit addition wraps.
  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_rot
      assign rot_idx[gi] = base + N'(gi);
      assign rot[gi]     = req[rot_idx[gi]];
    end
  endgenerate

  // Lowest set position in rotated order wins.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (rot[i]) begin
        hit = 1'b1;
        off = N'(i);
      end
    end
  end

  assign pick = base + off;

  // Dropping the request is treated exactly like done.
  assign drop        = done | ~req[code];
  assign release_now = drop | timeout_hit;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_reg;
  logic       tf_reg;

  // Forced release only when nothing else is releasing this cycle, so the
  // flag marks genuine timeouts.
  assign timeout_hit  = (state_reg == GRANT) && (cnt_reg == 8'(TIMEOUT - 1)) && !drop;
  assign timeout_flag = tf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tf_reg  <= 1'b0;
    end else begin
      tf_reg <= timeout_hit;
      // Count only while a grant continues; any new grant starts from zero.
      if (state_reg == GRANT && !release_now) begin
        cnt_reg <= cnt_reg + 8'd1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      code      <= '0;
      enabler   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            code      <= pick;
            enabler   <= 1'b1;
            state_reg <= GRANT;
          end else begin
            enabler   <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_reg <= code + 1'b1;
            if (hit) begin
              code <= pick;
            end else begin
              enabler   <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          enabler   <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_grant
      assign grant[gi] = enabler & (code == N'(gi));
    end
  endgenerate

endmodule
